key_led_ctrl: RTL

KEY_LED_CTRL -- requirements
Module: key_led_ctrl

---
 rtl/key_led_defs.sv | 23 ++
 rtl/key_debounce.sv | 54 +++++
 rtl/key_led_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/key_led_defs.sv
// Shared mode encodings and mode-sequencing helpers for the key-driven LED controller.
package key_led_defs;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_e;

    // OFF -> ON -> SLOW -> FAST -> OFF; the 2-bit increment wraps naturally.
    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(MODE_W'(m) + MODE_W'(1));
    endfunction

    // LED level taken on the edge a mode is entered.
    function automatic logic entry_led(input mode_e m);
        return (m != MODE_OFF);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, counter-based debounce and one-cycle press strobe for an active-low key.
module key_debounce #(
    parameter logic [19:0] DEB_MAX = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_pulse
);

    localparam int unsigned DEB_W = $clog2(32'(DEB_MAX) + 32'd1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             pulse_q, pulse_d;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    // Accept a new level only after DEB_MAX consecutive mismatching edges; strobe on press only.
    always_comb begin
        sync1_d   = key_in;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        pulse_d   = 1'b0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_W'(DEB_MAX - 20'd1)) begin
                deb_d   = sync2_q;
                pulse_d = deb_q & ~sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign key_pulse = pulse_q;

endmodule

// File: rtl/key_led_ctrl.sv
// Push-button cycled LED controller: OFF, steady ON, slow blink, fast blink.
module key_led_ctrl
    import key_led_defs::*;
#(
    parameter logic [19:0] DEB_MAX   = 20'd999_999,
    parameter logic [24:0] SLOW_HALF = 25'd24_999_999,
    parameter logic [24:0] FAST_HALF = 25'd4_999_999
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              key1,
    output logic              led_out,
    output logic [MODE_W-1:0] mode,
    output logic              key_pulse
);

    localparam int unsigned HALF_MAX = (32'(SLOW_HALF) > 32'(FAST_HALF)) ? 32'(SLOW_HALF)
                                                                         : 32'(FAST_HALF);
    localparam int unsigned BLK_W    = $clog2(HALF_MAX + 32'd1);

    mode_e            mode_q, mode_d;
    logic             led_q, led_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [BLK_W-1:0] half_m1;
    logic             press;

    key_debounce #(
        .DEB_MAX (DEB_MAX)
    ) u_key_debounce (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key_in    (key1),
        .key_pulse (press)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q    <= MODE_OFF;
            led_q     <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            mode_q    <= mode_d;
            led_q     <= led_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign half_m1 = (mode_q == MODE_SLOW) ? BLK_W'(SLOW_HALF - 25'd1)
                                           : BLK_W'(FAST_HALF - 25'd1);

    // Mode sequencing and blink; an accepted press overrides a same-cycle blink toggle.
    always_comb begin
        mode_d    = mode_q;
        led_d     = led_q;
        blk_cnt_d = '0;
        unique case (mode_q)
            MODE_OFF: led_d = 1'b0;
            MODE_ON:  led_d = 1'b1;
            MODE_SLOW, MODE_FAST: begin
                if (blk_cnt_q == half_m1) begin
                    led_d = ~led_q;
                end else begin
                    blk_cnt_d = blk_cnt_q + BLK_W'(1);
                end
            end
            default: led_d = 1'b0;
        endcase
        if (press) begin
            mode_d    = next_mode(mode_q);
            led_d     = entry_led(next_mode(mode_q));
            blk_cnt_d = '0;
        end
    end

    assign led_out   = led_q;
    assign mode      = mode_q;
    assign key_pulse = press;

endmodule
